cache_flush_ctrl: RTL and testbench
===================================

# cache_flush_ctrl

Sequencer that walks every set and way of a set-associative cache on a flush request, writing back dirty lines over a request/acknowledge handshake and clearing their dirty bits, with an optional whole-cache invalidate at the end. It sits beside the cache arrays and replacement logic. While busy, it drives the array address mux (set and way select). The cache controller and bus interface consume its writeback and clear strobes.

## Interface
- NUMWAYS, 4, associativity (power of 2, ≥2)
- NUMLINES, 128, sets per way (power of 2, ≥2)
- SETLEN, $clog2(NUMLINES), set index width
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- FlushReq  in  1  start flush; sampled only in IDLE
- InvalReq  in  1  invalidate request; sampled only in IDLE
- DirtyWay  in  NUMWAYS  dirty bits of the set at FlushSet, valid the cycle after FlushSet is presented
- WritebackAck  in  1  bus accepted the line writeback
- Busy  out  1  sequencer active; the array address mux selects FlushSet
- FlushSet  out  SETLEN  set index under inspection
- FlushWay  out  NUMWAYS  one-hot way under inspection; 0 in IDLE
- WritebackReq  out  1  write back line (FlushSet, FlushWay)
- ClearDirty  out  1  one-cycle strobe: clear dirty bit of (FlushSet, FlushWay)
- InvalidateCache  out  1  one-cycle strobe: clear all valid bits
- FlushDone  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, CHECK, WB, CLEAN, INVAL, DONE.
- IDLE:
  - FlushReq=1 → READ with set=0, way=0.
  - InvalReq alone → INVAL.
  - Both high → flush, then INVAL before DONE.
  - Requests in any other state are ignored and not queued.
- READ: present FlushSet/FlushWay → CHECK.
- CHECK: if DirtyWay[way]=1 → WB. Otherwise advance: way+1; on the last way, way=0 and set+1.
  - Last set and last way → INVAL if invalidate was latched, else DONE.
  - All other cases → READ.
- WB: hold WritebackReq=1 with FlushSet/FlushWay stable until WritebackAck=1 → CLEAN. WritebackAck outside WB is ignored.
- CLEAN: ClearDirty=1, then advance exactly as for a clean CHECK.
- INVAL: InvalidateCache=1 → DONE.
- DONE: FlushDone=1 → IDLE.
- Counters wrap to 0 on completion. There is no set or way overflow beyond NUMLINES-1 / NUMWAYS-1.
- Reset values: all outputs 0, state IDLE, counters 0, latched invalidate 0.
- Reset asserted mid-operation aborts immediately:
  - WritebackReq drops.
  - No ClearDirty or FlushDone is emitted.

## Timing
- Request sampled at end of cycle 0; Busy=1 from cycle 1 through the DONE cycle inclusive.
- Clean line costs 2 cycles (READ, CHECK).
- Dirty line costs 3 + (cycles waiting for ack) (READ, CHECK, WB≥1, CLEAN).
- Clean cache, step mode: last CHECK at cycle 2·NUMLINES·NUMWAYS; DONE one cycle later; IDLE after that.
- InvalReq only: INVAL in cycle 1, DONE in cycle 2.

## Configuration
- CACHE_FLUSH_DIRTYSCAN_EN defined:
  - Per set, CHECK captures DirtyWay into a pending mask and selects the lowest set bit (priority one-hot) as FlushWay.
  - CLEAN clears that mask bit and returns to CHECK without a re-read.
  - Empty mask advances to the next set.
  - A clean set costs 2 cycles total.
- Undefined: step mode as above, one way per READ/CHECK pair.
- Port list is identical in both builds.

## Structure
- Package cache_flush_pkg holds the state enum typedef.
- Sub-module cache_flush_idx holds the set/way counter pair: advance, last-line detect, one-hot way output.
- Scan mode reuses the existing priorityonehot.

## Test plan
- NUMLINES=4, NUMWAYS=2, all clean, FlushReq pulse at cycle 0 → no WritebackReq; FlushDone at cycle 17 (step mode); Busy cycles 1–17.
- Set 2 way 1 dirty, ack delayed 3 cycles → WritebackReq held 4 cycles with FlushSet=2, FlushWay=2'b10; ClearDirty one cycle after ack; flush then completes normally.
- FlushReq and InvalReq together → InvalidateCache pulses exactly once, the cycle before FlushDone, after the last CHECK.
- Reset asserted while in WB → next cycle all outputs 0, no FlushDone; a new FlushReq restarts at set 0.
- FlushReq and WritebackAck pulsed during Busy → ignored, no second flush; exactly one FlushDone.
- With CACHE_FLUSH_DIRTYSCAN_EN, set 0 ways 0 and 3 dirty (NUMWAYS=4) → writebacks for FlushWay 4'b0001 then 4'b1000 with a single READ; clean cache of 4 sets finishes in 9 cycles.

Source files
------------

// File: rtl/cache_flush_pkg.sv
// Shared types for the cache flush sequencer: FSM state encoding and the
// lowest-dirty-way selector used by the dirty-scan build.
package cache_flush_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB,
    CLEAN,
    INVAL,
    DONE
  } flush_state_e;

  localparam int unsigned MAXWAYS = 32;

  // Lowest set bit of a way mask as a one-hot vector (zero stays zero).
  function automatic logic [MAXWAYS-1:0] priorityonehot(input logic [MAXWAYS-1:0] mask);
    return mask & (~mask + MAXWAYS'(1));
  endfunction

endpackage

// File: rtl/cache_flush_if.sv
// Flush sequencer bundle: requests and dirty bits toward the sequencer,
// array select and writeback/clear/invalidate strobes back to the cache.
interface cache_flush_if #(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned NUMLINES = 128
);
  localparam int unsigned SETLEN = $clog2(NUMLINES);

  logic               FlushReq;
  logic               InvalReq;
  logic [NUMWAYS-1:0] DirtyWay;
  logic               WritebackAck;
  logic               Busy;
  logic [SETLEN-1:0]  FlushSet;
  logic [NUMWAYS-1:0] FlushWay;
  logic               WritebackReq;
  logic               ClearDirty;
  logic               InvalidateCache;
  logic               FlushDone;

  modport master (
    input  FlushReq, InvalReq, DirtyWay, WritebackAck,
    output Busy, FlushSet, FlushWay, WritebackReq, ClearDirty, InvalidateCache, FlushDone
  );

  modport slave (
    output FlushReq, InvalReq, DirtyWay, WritebackAck,
    input  Busy, FlushSet, FlushWay, WritebackReq, ClearDirty, InvalidateCache, FlushDone
  );

endinterface

// File: rtl/cache_flush_idx.sv
// Set/way scan position of the flush sequencer. With CACHE_FLUSH_DIRTYSCAN_EN
// the way is loaded from the dirty-way selection instead of being stepped.
module cache_flush_idx #(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned NUMLINES = 128,
  localparam int unsigned SETLEN  = $clog2(NUMLINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               adv,
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
  input  logic               ld,
  input  logic [NUMWAYS-1:0] sel,
`endif
  output logic [SETLEN-1:0]  set_idx,
  output logic [NUMWAYS-1:0] way_oh,
  output logic               last
);

`ifdef CACHE_FLUSH_DIRTYSCAN_EN
  assign last = (set_idx == SETLEN'(NUMLINES - 1));

  // Way is zero between sets; a dirty selection is loaded per writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_idx <= '0;
      way_oh  <= '0;
    end else if (start) begin
      set_idx <= '0;
      way_oh  <= '0;
    end else if (adv) begin
      set_idx <= last ? '0 : set_idx + SETLEN'(1);
      way_oh  <= '0;
    end else if (ld) begin
      way_oh  <= sel;
    end
  end
`else
  assign last = (set_idx == SETLEN'(NUMLINES - 1)) && way_oh[NUMWAYS-1];

  // One-hot way rotates; carrying out of the last way bumps the set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_idx <= '0;
      way_oh  <= '0;
    end else if (start) begin
      set_idx <= '0;
      way_oh  <= NUMWAYS'(1);
    end else if (adv) begin
      if (last) begin
        set_idx <= '0;
        way_oh  <= '0;
      end else if (way_oh[NUMWAYS-1]) begin
        set_idx <= set_idx + SETLEN'(1);
        way_oh  <= NUMWAYS'(1);
      end else begin
        way_oh  <= way_oh << 1;
      end
    end
  end
`endif

endmodule

// File: rtl/cache_flush_ctrl.sv
// Cache flush sequencer: walks every set/way, writes back and cleans dirty lines,
// optionally invalidates the whole cache. Build macro: CACHE_FLUSH_DIRTYSCAN_EN.
module cache_flush_ctrl
  import cache_flush_pkg::*;
#(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned NUMLINES = 128
) (
  input logic            clk,
  input logic            reset,
  cache_flush_if.master  bus
);

  localparam int unsigned SETLEN = $clog2(NUMLINES);

  flush_state_e       state;
  flush_state_e       adv_state_c;
  logic               inv_q;
  logic               busy_q, wbreq_q, clr_q, inval_q, done_q;
  logic               start_c, adv_c, dirty_c, last_c;
  logic [SETLEN-1:0]  set_idx;
  logic [NUMWAYS-1:0] way_oh;

`ifdef CACHE_FLUSH_DIRTYSCAN_EN
  logic [NUMWAYS-1:0] pend_q, cur_c, sel_c;
  logic               fresh_q;
`endif

  // Index control and the state reached by moving past the current line.
  always_comb begin
    start_c = (state == IDLE) && bus.FlushReq;
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
    cur_c   = fresh_q ? bus.DirtyWay : pend_q;
    sel_c   = NUMWAYS'(priorityonehot(MAXWAYS'(cur_c)));
    dirty_c = |cur_c;
    adv_c   = (state == CHECK) && !dirty_c;
`else
    dirty_c = |(bus.DirtyWay & way_oh);
    adv_c   = ((state == CHECK) && !dirty_c) || (state == CLEAN);
`endif
    if (!last_c)    adv_state_c = READ;
    else if (inv_q) adv_state_c = INVAL;
    else            adv_state_c = DONE;
  end

  cache_flush_idx #(
    .NUMWAYS  (NUMWAYS),
    .NUMLINES (NUMLINES)
  ) u_idx (
    .clk     (clk),
    .reset   (reset),
    .start   (start_c),
    .adv     (adv_c),
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
    .ld      ((state == CHECK) && dirty_c),
    .sel     (sel_c),
`endif
    .set_idx (set_idx),
    .way_oh  (way_oh),
    .last    (last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      wbreq_q <= 1'b0;
      clr_q   <= 1'b0;
      inval_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
      pend_q  <= '0;
      fresh_q <= 1'b0;
`endif
    end else begin
      clr_q   <= 1'b0;
      inval_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.FlushReq) begin
            state  <= READ;
            busy_q <= 1'b1;
            inv_q  <= bus.InvalReq;
          end else if (bus.InvalReq) begin
            state   <= INVAL;
            busy_q  <= 1'b1;
            inval_q <= 1'b1;
          end
        end
        READ: begin
          state <= CHECK;
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
          fresh_q <= 1'b1;
`endif
        end
        CHECK: begin
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
          fresh_q <= 1'b0;
          pend_q  <= cur_c;
`endif
          if (dirty_c) begin
            state   <= WB;
            wbreq_q <= 1'b1;
          end else begin
            state   <= adv_state_c;
            inval_q <= (adv_state_c == INVAL);
            done_q  <= (adv_state_c == DONE);
          end
        end
        WB: begin
          if (bus.WritebackAck) begin
            state   <= CLEAN;
            wbreq_q <= 1'b0;
            clr_q   <= 1'b1;
          end
        end
        CLEAN: begin
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
          // Remaining dirty ways of this set are served without a re-read.
          state  <= CHECK;
          pend_q <= pend_q & ~way_oh;
`else
          state   <= adv_state_c;
          inval_q <= (adv_state_c == INVAL);
          done_q  <= (adv_state_c == DONE);
`endif
        end
        INVAL: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          inv_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          wbreq_q <= 1'b0;
          inv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy            = busy_q;
  assign bus.FlushSet        = set_idx;
  assign bus.FlushWay        = way_oh;
  assign bus.WritebackReq    = wbreq_q;
  assign bus.ClearDirty      = clr_q;
  assign bus.InvalidateCache = inval_q;
  assign bus.FlushDone       = done_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl: vector table, hand sequences and
// randomized flushes compared against a cycle-cost model of the flush.
module tb_cache_flush_ctrl;

  localparam int unsigned NW    = 2;
  localparam int unsigned NL    = 4;
  localparam int unsigned LINES = NW * NL;

  logic clk;
  logic reset;
  logic [NW-1:0] dirty_mem [NL];
  int checks;
  int errors;
  int dly_q[$];

  cache_flush_if #(.NUMWAYS(NW), .NUMLINES(NL)) bus ();

  cache_flush_ctrl #(.NUMWAYS(NW), .NUMLINES(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The cache arrays: dirty bits of the presented set.
  assign bus.DirtyWay = dirty_mem[bus.FlushSet];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             fl;
    bit             iv;
    logic [LINES-1:0] dmap;
    int             dly;
    bit             noise;
    int             exp_done;
    int             exp_nwb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NW-1:0] oh);
    int r = -1;
    for (int i = 0; i < NW; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // One flush/invalidate operation: model the outcome, drive it, compare.
  task automatic run_flush(input bit fl, input bit iv, input logic [LINES-1:0] dmap,
                           input bit noise, output int done_cyc, output int nwb);
    int exp_wb[$];
    int exp_dly[$];
    int got_wb[$];
    int held_q[$];
    int clr_l[$];
    int exp_done, cost, k, cyc, held, wbi, busy_cnt, done_cnt, inv_cnt, inv_cyc;
    int unstable, line, d, left;

    for (int s = 0; s < NL; s++) dirty_mem[s] = dmap[s*NW +: NW];

    // Reference: lines visited set-major, way-minor; cost per line from the rules.
    cost = 0;
    k    = 0;
    if (fl) begin
      for (int s = 0; s < NL; s++) begin
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
        cost += 2;
`endif
        for (int w = 0; w < NW; w++) begin
          if (dmap[s*NW + w]) begin
            exp_wb.push_back(s*NW + w);
            exp_dly.push_back(dly_q[k]);
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
            cost += 3 + dly_q[k];
`else
            cost += 4 + dly_q[k];
`endif
            k++;
          end else begin
`ifndef CACHE_FLUSH_DIRTYSCAN_EN
            cost += 2;
`endif
          end
        end
      end
      exp_done = 1 + cost + (iv ? 1 : 0);
    end else begin
      exp_done = 2;
    end

    done_cyc = 0; busy_cnt = 0; done_cnt = 0; inv_cnt = 0; inv_cyc = 0;
    held = 0; wbi = 0; unstable = 0;

    @(negedge clk);
    bus.FlushReq = fl;
    bus.InvalReq = iv;
    @(negedge clk);
    bus.FlushReq = 1'b0;
    bus.InvalReq = 1'b0;

    for (cyc = 1; cyc <= exp_done + 3; cyc++) begin
      line = int'(bus.FlushSet) * NW + oh2idx(bus.FlushWay);
      if (cyc == 1 && fl) begin
        chk("start_set", int'(bus.FlushSet), 0);
`ifdef CACHE_FLUSH_DIRTYSCAN_EN
        chk("start_way", int'(bus.FlushWay), 0);
`else
        chk("start_way", int'(bus.FlushWay), 1);
`endif
      end
      if (bus.Busy) busy_cnt++;
      if (bus.WritebackReq) begin
        if (held == 0) got_wb.push_back(line);
        else if (line != got_wb[got_wb.size()-1]) unstable++;
        held++;
        d = (wbi < exp_dly.size()) ? exp_dly[wbi] : 0;
        bus.WritebackAck = (held == d + 1);
        if (held == d + 1) begin
          held_q.push_back(held);
          held = 0;
          wbi++;
        end
      end else begin
        bus.WritebackAck = noise ? 1'($urandom % 2) : 1'b0;
      end
      if (bus.ClearDirty) begin
        clr_l.push_back(line);
        dirty_mem[bus.FlushSet] = dirty_mem[bus.FlushSet] & ~bus.FlushWay;
      end
      if (bus.InvalidateCache) begin
        inv_cnt++;
        inv_cyc = cyc;
      end
      if (bus.FlushDone) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      bus.FlushReq = noise && bus.Busy && ($urandom % 2 == 1);
      bus.InvalReq = noise && bus.Busy && ($urandom % 2 == 1);
      @(negedge clk);
    end
    bus.FlushReq     = 1'b0;
    bus.InvalReq     = 1'b0;
    bus.WritebackAck = 1'b0;

    nwb = got_wb.size();
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, exp_done);
    chk("busy_end", int'(bus.Busy), 0);
    chk("wb_count", got_wb.size(), exp_wb.size());
    for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++)
      chk("wb_line", got_wb[i], exp_wb[i]);
    for (int i = 0; i < held_q.size() && i < exp_dly.size(); i++)
      chk("wb_held", held_q[i], exp_dly[i] + 1);
    chk("clr_count", clr_l.size(), exp_wb.size());
    for (int i = 0; i < clr_l.size() && i < exp_wb.size(); i++)
      chk("clr_line", clr_l[i], exp_wb[i]);
    chk("wb_stable", unstable, 0);
    chk("inval_count", inv_cnt, iv ? 1 : 0);
    if (iv) chk("inval_cycle", inv_cyc, exp_done - 1);
    if (fl) begin
      left = 0;
      for (int s = 0; s < NL; s++) if (dirty_mem[s] != '0) left++;
      chk("dirty_left", left, 0);
    end
  endtask

  initial begin
    int dc, nw, n, seen;
    bit fl, iv, noise;
    logic [LINES-1:0] dm;
    logic [8:0] outs;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.FlushReq = 1'b0;
    bus.InvalReq = 1'b0;
    bus.WritebackAck = 1'b0;
    for (int s = 0; s < NL; s++) dirty_mem[s] = '0;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 17, 0};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 3, 1'b0, 22, 1};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 0, 1'b0, 18, 0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 2,  0};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 0, 1'b0, 33, 8};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 1, 1'b0, 24, 2};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 2, 1'b1, 21, 1};

    repeat (2) @(negedge clk);
    outs = {bus.Busy, bus.WritebackReq, bus.ClearDirty, bus.InvalidateCache,
            bus.FlushDone, bus.FlushSet, bus.FlushWay};
    chk("reset_outputs", int'(outs), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      dly_q.delete();
      repeat (LINES) dly_q.push_back(vecs[i].dly);
      run_flush(vecs[i].fl, vecs[i].iv, vecs[i].dmap, vecs[i].noise, dc, nw);
`ifndef CACHE_FLUSH_DIRTYSCAN_EN
      chk("table_done", dc, vecs[i].exp_done);
      chk("table_nwb", nw, vecs[i].exp_nwb);
`endif
    end

    // Reset while a writeback is pending aborts without completion strobes.
    for (int s = 0; s < NL; s++) dirty_mem[s] = '0;
    dirty_mem[2] = 2'b10;
    @(negedge clk);
    bus.FlushReq = 1'b1;
    @(negedge clk);
    bus.FlushReq = 1'b0;
    n = 0;
    while (!bus.WritebackReq && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wb", int'(bus.WritebackReq), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    outs = {bus.Busy, bus.WritebackReq, bus.ClearDirty, bus.InvalidateCache,
            bus.FlushDone, bus.FlushSet, bus.FlushWay};
    chk("abort_outputs", int'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.FlushDone || bus.ClearDirty || bus.Busy || bus.WritebackReq) seen++;
    end
    chk("abort_quiet", seen, 0);
    dly_q.delete();
    repeat (LINES) dly_q.push_back(0);
    run_flush(1'b1, 1'b0, 8'h20, 1'b0, dc, nw);

    // Randomized operations against the cost model.
    for (int r = 0; r < 24; r++) begin
      fl    = ($urandom % 4) != 0;
      iv    = 1'($urandom % 2);
      if (!fl && !iv) fl = 1'b1;
      dm    = LINES'($urandom);
      noise = 1'($urandom % 2);
      dly_q.delete();
      repeat (LINES) dly_q.push_back(int'($urandom_range(0, 3)));
      run_flush(fl, iv, dm, noise, dc, nw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
